// File: rtl/spm_pipe.sv
// spm_pipe: serial-parallel multiplier with a WIDTH-wide carry-save adder chain.
// The multiplier y is consumed LSB-first, one product bit p per RUN cycle, and the
// full 2*WIDTH-bit product is collected in prod behind a valid/ready handshake.
// Build option: define SPM_SIGNED_EN for two's-complement operands and product.
module spm_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(2*WIDTH)+1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               p,
   output logic               p_valid,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*WIDTH-1);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     x_q, x_d;
   logic [WIDTH-1:0]     y_q, y_d;
   logic [WIDTH-1:0]     s_q, s_d;
   logic [WIDTH-1:0]     c_q, c_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;

   logic [WIDTH-1:0]     sum_c;
   logic [WIDTH-1:0]     car_c;
   logic                 ybit;
   logic                 top_pp;
   logic                 top_in;
   logic                 fill;
   logic                 load;

   // full adder returning {carry, sum}
   function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   assign ybit = y_q[0];

`ifdef SPM_SIGNED_EN
   // The sign stage adds ~pp instead of -pp; each cycle that over-counts by one unit at
   // weight WIDTH-1, which over 2*WIDTH cycles sums to -2^(WIDTH-1) mod 2^(2*WIDTH).
   // A single carry-in of 1 at that weight on the first cycle cancels it.
   assign top_pp = ~(x_q[WIDTH-1] & ybit);
   assign top_in = (cnt_q == '0);
   assign fill   = y_q[WIDTH-1];
`else
   assign top_pp = x_q[WIDTH-1] & ybit;
   assign top_in = 1'b0;
   assign fill   = 1'b0;
`endif

   // CSA chain: stage i adds pp_i, the sum from stage i+1 (one weight down after the
   // shift) and its own stored carry; stage 0's sum is this cycle's product bit.
   always_comb begin
      sum_c = '0;
      car_c = '0;
      for (int i = 0; i < WIDTH-1; i++) begin
         {car_c[i], sum_c[i]} = fa(x_q[i] & ybit, s_q[i+1], c_q[i]);
      end
      {car_c[WIDTH-1], sum_c[WIDTH-1]} = fa(top_pp, top_in, c_q[WIDTH-1]);
   end

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign load      = in_valid && in_ready;
   assign p         = (state_q == RUN) ? sum_c[0] : 1'b0;
   assign p_valid   = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign prod      = prod_q;

   // next-state logic: operand load, per-cycle shift/accumulate, and handshake sequencing
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      s_d     = s_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      unique case (state_q)
         IDLE: begin
            if (load) begin
               x_d     = x;
               y_d     = y;
               s_d     = '0;
               c_d     = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d    = sum_c;
            c_d    = car_c;
            y_d    = {fill, y_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
            prod_d = {sum_c[0], prod_q[2*WIDTH-1:1]};
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (load) begin
                  x_d     = x;
                  y_d     = y;
                  s_d     = '0;
                  c_d     = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and datapath registers, all cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         s_q     <= '0;
         c_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         s_q     <= s_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

endmodule

// File: tb/tb_spm_pipe.sv
// Directed and random bench for spm_pipe at WIDTH=8; follows SPM_SIGNED_EN if defined.
module tb_spm_pipe;

   localparam int W = 8;
   localparam int N_RAND = 1000;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   x;
   logic [W-1:0]   y;
   logic           p;
   logic           p_valid;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] prod;
   logic           busy;

   int n_tests = 0;
   int n_fail  = 0;

   spm_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .p         (p),
      .p_valid   (p_valid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .prod      (prod),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   x;
      logic [W-1:0]   y;
      logic [2*W-1:0] prod;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int ai, bi;
`ifdef SPM_SIGNED_EN
      ai = int'($signed(a));
      bi = int'($signed(b));
`else
      ai = int'(a);
      bi = int'(b);
`endif
      return (2*W)'(ai * bi);
   endfunction

   // one full operation with out_ready held high; checks latency, p stream and prod
   task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] ya,
                         input string tag, input logic [2*W-1:0] exp);
      int cyc, first_pv, ov_cyc, npv;
      logic [2*W-1:0] stream;
      @(negedge clk);
      in_valid  = 1'b1;
      x         = xa;
      y         = ya;
      out_ready = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!in_ready) begin
         check({tag, "_accept_timeout"}, 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      x = W'($urandom);
      y = W'($urandom);
      cyc = 1; first_pv = -1; ov_cyc = -1; npv = 0; stream = '0;
      while (cyc <= 60 && ov_cyc < 0) begin
         if (p_valid) begin
            if (first_pv < 0) first_pv = cyc;
            if (npv < 2*W) stream[npv] = p;
            npv++;
         end
         if (out_valid) ov_cyc = cyc;
         else begin
            @(negedge clk);
            cyc++;
         end
      end
      check({tag, "_first_pvalid"}, first_pv, 1);
      check({tag, "_pvalid_count"}, npv, 2*W);
      check({tag, "_outvalid_cycle"}, ov_cyc, 2*W+1);
      check({tag, "_prod"}, prod, exp);
      check({tag, "_pstream"}, stream, exp);
   endtask

   initial begin
      logic [2*W-1:0] expq[$];
      logic [2*W-1:0] hold;
      logic [W-1:0]   nx, ny;
      int sent, got, pv_total, cyc;

`ifdef SPM_SIGNED_EN
      vecs[0] = '{8'hFF, 8'hFF, 16'h0001};
      vecs[1] = '{8'h80, 8'h7F, 16'hC080};
      vecs[2] = '{8'h80, 8'h80, 16'h4000};
      vecs[3] = '{8'h00, 8'hA5, 16'h0000};
      vecs[4] = '{8'h12, 8'h34, 16'h03A8};
      vecs[5] = '{8'h01, 8'hFF, 16'hFFFF};
      vecs[6] = '{8'hFF, 8'h01, 16'hFFFF};
      vecs[7] = '{8'hAB, 8'hCD, 16'h10EF};
      vecs[8] = '{8'h7F, 8'h7F, 16'h3F01};
      vecs[9] = '{8'h03, 8'h05, 16'h000F};
`else
      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
      vecs[1] = '{8'h80, 8'h7F, 16'h3F80};
      vecs[2] = '{8'h80, 8'h80, 16'h4000};
      vecs[3] = '{8'h00, 8'hA5, 16'h0000};
      vecs[4] = '{8'h12, 8'h34, 16'h03A8};
      vecs[5] = '{8'h01, 8'hFF, 16'h00FF};
      vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
      vecs[7] = '{8'hAB, 8'hCD, 16'h88EF};
      vecs[8] = '{8'h7F, 8'h7F, 16'h3F01};
      vecs[9] = '{8'h03, 8'h05, 16'h000F};
`endif

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_p", p, 0);
      check("rst_p_valid", p_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_prod", prod, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;

      // table of directed operand pairs
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].x, vecs[i].y, $sformatf("vec%0d", i), vecs[i].prod);
      end

      // backpressure: hold the result, then release with a same-cycle new operand
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1; x = 8'hAB; y = 8'hCD;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("bp_outvalid_seen", out_valid, 1);
      hold = vecs[7].prod;
      for (int k = 0; k < 10; k++) begin
         check($sformatf("bp_hold%0d_outvalid", k), out_valid, 1);
         check($sformatf("bp_hold%0d_prod", k), prod, hold);
         check($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1; x = 8'h03; y = 8'h05;
      #1;
      check("bp_same_cycle_ready", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_restart_pvalid", p_valid, 1);
      check("bp_restart_outvalid", out_valid, 0);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("bp_second_prod", prod, 16'h000F);

      // asynchronous reset in the middle of RUN
      @(negedge clk);
      in_valid = 1'b1; x = 8'h12; y = 8'h34;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("midrst_busy_before", busy, 1);
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_p_valid", p_valid, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_prod", prod, 0);
      check("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      run_op(8'h12, 8'h34, "after_rst", 16'h03A8);

      // random operands with random consumer stalls against a reference multiply
      sent = 0; got = 0; pv_total = 0; cyc = 0;
      nx = W'($urandom); ny = W'($urandom);
      while (got < N_RAND && cyc < 60000) begin
         @(negedge clk);
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (sent < N_RAND);
         x = nx; y = ny;
         #1;
         if (p_valid) pv_total++;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) check("rand_extra_result", 1, 0);
            else check($sformatf("rand_prod%0d", got), prod, expq.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(ref_mul(nx, ny));
            sent++;
            nx = W'($urandom); ny = W'($urandom);
         end
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("rand_sent", sent, N_RAND);
      check("rand_received", got, N_RAND);
      check("rand_run_cycles", pv_total, 2*W*N_RAND);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spm_pipe.md
Name: spm_pipe

Overview:
- Parametrised serial-parallel multiplier (SPM) with valid/ready handshakes on input and output. Successor to the fixed-width spm core.
- Computes x*y from a WIDTH-wide carry-save adder (CSA) chain. y is shifted in LSB-first internally; one product bit p is emitted per cycle.
- The full 2*WIDTH-bit product is collected in a result register.
- Sits between an operand producer and a result consumer in the arithmetic datapath. Also serves as the next equivalence-check target, with a serial p stream comparable to the spm core.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..32.
- CNT_W, $clog2(2*WIDTH)+1: width of the internal bit counter. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronised externally.
- in_valid  in  1  operand pair x/y presented.
- in_ready  out  1  block can accept an operand pair this cycle.
- x  in  WIDTH  parallel multiplicand; sampled on input handshake.
- y  in  WIDTH  multiplier; sampled on input handshake, then shifted LSB-first.
- p  out  1  serial product bit for the current RUN cycle.
- p_valid  out  1  p is meaningful this cycle.
- out_valid  out  1  prod holds a complete result.
- out_ready  in  1  consumer accepts prod.
- prod  out  2*WIDTH  full product.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; x_reg, y_sh, CSA sum/carry flops, counter and prod cleared to 0. Outputs: in_ready=1, p=0, p_valid=0, out_valid=0, prod=0, busy=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load x_reg<=x, y_sh<=y, clear CSA state and counter, go to RUN.
  - RUN:
    - in_ready=0; p_valid=1; p = LSB output of the CSA chain for the current y_sh bit.
    - Each cycle: y_sh shifts right, with the fill bit 0 (unsigned). The counter increments, and p is shifted into prod from the MSB side, so prod holds the LSB-first stream right-aligned after 2*WIDTH bits.
    - Exactly 2*WIDTH RUN cycles, counter 0..2*WIDTH-1. When counter==2*WIDTH-1, go to DONE.
  - DONE:
    - out_valid=1; p_valid=0; prod stable.
    - On out_ready: if in_valid also=1, accept the new operands the same cycle (in_ready=1) and go to RUN; else go to IDLE.
    - Without out_ready: hold indefinitely, in_ready=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready.
- Latency: first p_valid one cycle after the input handshake. out_valid rises 2*WIDTH+1 cycles after the handshake edge. Throughput is one product per 2*WIDTH+1 cycles with out_ready held high.
- Arithmetic: prod = x*y exact, no truncation; 2*WIDTH bits always suffice. The CSA carry chain drains during the upper WIDTH cycles while y_sh is zero-filled.
- x and y changing while not in a handshake have no effect.
- in_valid during RUN is ignored and not lost: the producer must hold it per valid/ready rules.
- Reset mid-RUN or mid-DONE: the result is discarded; all outputs return to reset values asynchronously.

Optional Feature:
- Macro: SPM_SIGNED_EN.
- Defined: x and y are two's complement, and prod is the signed 2*WIDTH-bit product.
  - y_sh fills with its sign bit instead of 0.
  - The CSA stage for x_reg[WIDTH-1] subtracts rather than adds its partial product, with a correction carry-in.
  - Latency and handshakes are unchanged.
- Undefined: unsigned-only, as described under Behaviour.

Test Plan (WIDTH=8):
- Reset, then x=0xFF, y=0xFF, single handshake, out_ready=1 → 16 p_valid cycles. out_valid 17 cycles after the handshake, with prod=0xFE01. LSB-first p stream = 1,0,0,0,0,0,0,0,0,1,1,1,1,1,1,1.
- x=0x80, y=0x7F unsigned → prod=0x3F80. x=0x00, y=0xA5 → prod=0x0000, all p=0.
- Backpressure: result ready, out_ready=0 for 10 cycles → out_valid stays 1, prod stable, in_ready=0. Raise out_ready together with in_valid (x=3, y=5) → same-cycle accept; next result prod=0x000F.
- Reset mid-operation: x=0x12, y=0x34, assert rst at RUN cycle 5 → busy, p_valid and out_valid drop immediately, prod=0. After release, x=0x12, y=0x34 gives prod=0x03A8.
- SPM_SIGNED_EN: x=0xFF, y=0xFF → prod=0x0001. x=0x80, y=0x7F → prod=0xC080. x=0x80, y=0x80 → prod=0x4000.
- Random 1000 operand pairs with random out_ready stalls → every prod matches the reference multiply. No handshake is dropped or duplicated.
